// File: rtl/hash_query_ctrl_pkg.sv
// Shared types, FSM encodings and the key-folding hash used by hash_query_ctrl.
package hash_query_ctrl_pkg;

    typedef enum logic {
        LOOK_UP_QUERY = 1'b0,
        INSERT_QUERY  = 1'b1
    } hash_query_t;

    // Result status is 3 bits wide; ST_INVALID has its own code instead of aliasing ST_MISS.
    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_HIT     = 3'd1,
        ST_MISS    = 3'd2,
        ST_COLLIDE = 3'd3,
        ST_INVALID = 3'd4
    } hash_status_t;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t S_INIT  = 3'd0;
    localparam ctrl_state_t S_IDLE  = 3'd1;
    localparam ctrl_state_t S_QUERY = 3'd2;
    localparam ctrl_state_t S_CHECK = 3'd3;
    localparam ctrl_state_t S_WRITE = 3'd4;
    localparam ctrl_state_t S_RESP  = 3'd5;

    // Bit b of the key lands in index bit (b mod keyW): the XOR of LSB-aligned
    // keyW-bit chunks, with the top chunk implicitly zero-padded.
    function automatic logic [31:0] hash_fold(input logic [127:0] key,
                                              input int keyInW,
                                              input int keyW);
        logic [31:0] folded;
        folded = '0;
        for (int b = 0; b < 128; b++) begin
            if (b < keyInW) begin
                folded[5'(b % keyW)] = folded[5'(b % keyW)] ^ key[b];
            end
        end
        return folded;
    endfunction

endpackage

// File: rtl/hash_query_ctrl.sv
// Request controller for hash_table: zero-fills the table after reset, then runs one
// insert/lookup at a time through query, check and optional write before reporting status.
module hash_query_ctrl
    import hash_query_ctrl_pkg::*;
#(
    parameter int KEY_IN_W = 48,
    parameter int KEY_W    = 12,
    parameter int VAL_W    = 32,
    parameter int INIT_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_query_i,
    input  logic [KEY_IN_W-1:0] req_key_i,
    input  logic [VAL_W-1:0]    req_val_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [2:0]          res_status_o,
    output logic [KEY_W-1:0]    res_hash_o,
    output logic                init_done_o,
    output logic                tbl_wr_en_o,
    output logic                tbl_query_o,
    output logic [KEY_W-1:0]    tbl_wr_key_o,
    output logic [KEY_W-1:0]    tbl_rd_key_o,
    output logic [VAL_W-1:0]    tbl_val_o,
    input  logic                tbl_resp_i
);

    localparam ctrl_state_t RESET_STATE = (INIT_EN != 0) ? S_INIT : S_IDLE;

    ctrl_state_t        state_q, state_d;
    logic [KEY_W-1:0]   cnt_q, cnt_d;
    logic               initDone_q, initDone_d;
    logic               resValid_q, resValid_d;
    logic [2:0]         resStatus_q, resStatus_d;
    logic [KEY_W-1:0]   resHash_q, resHash_d;
    logic               tblWrEn_q, tblWrEn_d;
    logic               tblQuery_q, tblQuery_d;
    logic [KEY_W-1:0]   tblWrKey_q, tblWrKey_d;
    logic [KEY_W-1:0]   tblRdKey_q, tblRdKey_d;
    logic [VAL_W-1:0]   tblVal_q, tblVal_d;

    logic [31:0]        foldFull;
    logic [KEY_W-1:0]   reqHash;
    logic               unusedFoldBits;

    assign foldFull       = hash_fold(128'(req_key_i), KEY_IN_W, KEY_W);
    assign reqHash        = foldFull[KEY_W-1:0];
    assign unusedFoldBits = ^foldFull[31:KEY_W];

    // Every output register is loaded on the edge that enters the state it belongs to,
    // so tbl_wr_en_o is high during exactly the INIT sweep and the single WRITE cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        initDone_d  = initDone_q | (state_q != S_INIT);
        resValid_d  = resValid_q;
        resStatus_d = resStatus_q;
        resHash_d   = resHash_q;
        tblWrEn_d   = 1'b0;
        tblQuery_d  = tblQuery_q;
        tblWrKey_d  = tblWrKey_q;
        tblRdKey_d  = tblRdKey_q;
        tblVal_d    = tblVal_q;
        case (state_q)
            S_INIT: begin
                tblWrEn_d  = 1'b1;
                tblWrKey_d = cnt_q;
                tblVal_d   = '0;
                cnt_d      = cnt_q + {{(KEY_W-1){1'b0}}, 1'b1};
                if (cnt_q == '1) begin
                    state_d    = S_IDLE;
                    initDone_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (req_valid_i) begin
                    resHash_d = reqHash;
                    if ((req_query_i == INSERT_QUERY) && (req_val_i == '0)) begin
                        resStatus_d = ST_INVALID;
                        resValid_d  = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        tblQuery_d = req_query_i;
                        tblRdKey_d = reqHash;
                        tblWrKey_d = reqHash;
                        tblVal_d   = req_val_i;
                        state_d    = S_QUERY;
                    end
                end
            end
            S_QUERY: begin
                state_d = S_CHECK;
            end
            // For an insert the table answers "slot empty"; a full slot is never overwritten.
            S_CHECK: begin
                if (tblQuery_q == INSERT_QUERY) begin
                    if (tbl_resp_i) begin
                        tblWrEn_d = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        resStatus_d = ST_COLLIDE;
                        resValid_d  = 1'b1;
                        state_d     = S_RESP;
                    end
                end else begin
                    resStatus_d = tbl_resp_i ? ST_HIT : ST_MISS;
                    resValid_d  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WRITE: begin
                resStatus_d = ST_OK;
                resValid_d  = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready_i) begin
                    resValid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            initDone_q  <= 1'b0;
            resValid_q  <= 1'b0;
            resStatus_q <= '0;
            resHash_q   <= '0;
            tblWrEn_q   <= 1'b0;
            tblQuery_q  <= 1'b0;
            tblWrKey_q  <= '0;
            tblRdKey_q  <= '0;
            tblVal_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            initDone_q  <= initDone_d;
            resValid_q  <= resValid_d;
            resStatus_q <= resStatus_d;
            resHash_q   <= resHash_d;
            tblWrEn_q   <= tblWrEn_d;
            tblQuery_q  <= tblQuery_d;
            tblWrKey_q  <= tblWrKey_d;
            tblRdKey_q  <= tblRdKey_d;
            tblVal_q    <= tblVal_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign res_valid_o  = resValid_q;
    assign res_status_o = resStatus_q;
    assign res_hash_o   = resHash_q;
    assign init_done_o  = initDone_q;
    assign tbl_wr_en_o  = tblWrEn_q;
    assign tbl_query_o  = tblQuery_q;
    assign tbl_wr_key_o = tblWrKey_q;
    assign tbl_rd_key_o = tblRdKey_q;
    assign tbl_val_o    = tblVal_q;

endmodule

// File: tb/tb_hash_query_ctrl.sv
// Bench for hash_query_ctrl: a behavioural hash_table sits beside the DUT, and results are
// checked against fixed vectors, hand-written corner sequences and a keyed reference model.
module tb_hash_query_ctrl;
    import hash_query_ctrl_pkg::*;

    localparam int KEY_IN_W = 48;
    localparam int KEY_W    = 12;
    localparam int VAL_W    = 32;
    localparam int DEPTH    = 1 << KEY_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid_i = 1'b0;
    logic                req_ready_o;
    logic                req_query_i = 1'b0;
    logic [KEY_IN_W-1:0] req_key_i = '0;
    logic [VAL_W-1:0]    req_val_i = '0;
    logic                res_valid_o;
    logic                res_ready_i = 1'b1;
    logic [2:0]          res_status_o;
    logic [KEY_W-1:0]    res_hash_o;
    logic                init_done_o;
    logic                tbl_wr_en_o;
    logic                tbl_query_o;
    logic [KEY_W-1:0]    tbl_wr_key_o;
    logic [KEY_W-1:0]    tbl_rd_key_o;
    logic [VAL_W-1:0]    tbl_val_o;
    logic                tblResp = 1'b0;

    hash_query_ctrl #(
        .KEY_IN_W(KEY_IN_W), .KEY_W(KEY_W), .VAL_W(VAL_W), .INIT_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_query_i(req_query_i), .req_key_i(req_key_i), .req_val_i(req_val_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_status_o(res_status_o), .res_hash_o(res_hash_o),
        .init_done_o(init_done_o),
        .tbl_wr_en_o(tbl_wr_en_o), .tbl_query_o(tbl_query_o),
        .tbl_wr_key_o(tbl_wr_key_o), .tbl_rd_key_o(tbl_rd_key_o),
        .tbl_val_o(tbl_val_o), .tbl_resp_i(tblResp)
    );

    always #5 clk = ~clk;

    // Behavioural hash_table plus a write monitor that checks the init sweep order.
    logic [VAL_W-1:0] mem [DEPTH];
    int               wrCount = 0;
    int               seqErrs = 0;
    logic [KEY_W-1:0] lastWrKey = '0;
    logic [VAL_W-1:0] lastWrVal = '0;
    logic             seqCheck = 1'b0;
    int               seqBase = 0;

    always @(posedge clk) begin
        if (tbl_query_o == INSERT_QUERY) tblResp <= (mem[tbl_rd_key_o] == '0);
        else                             tblResp <= (mem[tbl_rd_key_o] == tbl_val_o);
        if (tbl_wr_en_o) begin
            mem[tbl_wr_key_o] <= tbl_val_o;
            wrCount   <= wrCount + 1;
            lastWrKey <= tbl_wr_key_o;
            lastWrVal <= tbl_val_o;
            if (seqCheck && ((tbl_wr_key_o != KEY_W'(wrCount - seqBase)) || (tbl_val_o != '0)))
                seqErrs <= seqErrs + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [VAL_W-1:0] refMem [int];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [KEY_W-1:0] tbFold(input logic [KEY_IN_W-1:0] key);
        logic [KEY_W-1:0]    acc;
        logic [KEY_IN_W-1:0] rest;
        acc  = '0;
        rest = key;
        while (rest != '0) begin
            acc  = acc ^ rest[KEY_W-1:0];
            rest = rest >> KEY_W;
        end
        return acc;
    endfunction

    function automatic int expLatency(input logic [2:0] st);
        if (st == 3'(ST_INVALID)) return 1;
        if (st == 3'(ST_OK))      return 4;
        return 3;
    endfunction

    // Called at a negedge with rst_n low; releases reset and checks the full zero-fill sweep.
    task automatic runInit();
        int lowCount;
        int errBase;
        seqCheck = 1'b1;
        seqBase  = wrCount;
        errBase  = seqErrs;
        rst_n    = 1'b1;
        lowCount = 0;
        while (!req_ready_o && lowCount < 6000) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput("initReadyLowCycles", 64'(lowCount), 64'(DEPTH));
        checkOutput("initDoneAtIdle", 64'(init_done_o), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("initWriteCount", 64'(wrCount - seqBase), 64'(DEPTH));
        checkOutput("initSweepOrder", 64'(seqErrs - errBase), 64'd0);
        seqCheck = 1'b0;
        refMem.delete();
    endtask

    task automatic applyStimulus(input logic q, input logic [KEY_IN_W-1:0] k, input logic [VAL_W-1:0] v,
                                 output logic [2:0] st, output logic [KEY_W-1:0] h, output int lat,
                                 output int wrs, output logic [KEY_W-1:0] wk, output logic [VAL_W-1:0] wv);
        int waitCyc;
        int wrStart;
        req_query_i = q;
        req_key_i   = k;
        req_val_i   = v;
        req_valid_i = 1'b1;
        res_ready_i = 1'b1;
        waitCyc = 0;
        while (!req_ready_o && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("reqAccepted", 64'(req_ready_o), 64'd1);
        wrStart = wrCount;
        @(negedge clk);
        req_valid_i = 1'b0;
        lat = 1;
        while (!res_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        st = res_status_o;
        h  = res_hash_o;
        @(negedge clk);
        wrs = wrCount - wrStart;
        wk  = lastWrKey;
        wv  = lastWrVal;
    endtask

    typedef struct {
        logic                q;
        logic [KEY_IN_W-1:0] key;
        logic [VAL_W-1:0]    val;
        logic [2:0]          expSt;
        logic [KEY_W-1:0]    expHash;
        int                  expLat;
        int                  expWr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]          st;
        logic [KEY_W-1:0]    h;
        logic [KEY_W-1:0]    wk;
        logic [VAL_W-1:0]    wv;
        logic [KEY_IN_W-1:0] pool [12];
        logic [KEY_IN_W-1:0] k;
        logic [KEY_W-1:0]    x;
        logic [VAL_W-1:0]    v;
        logic [2:0]          expSt;
        logic                q;
        int                  lat;
        int                  wrs;
        int                  waitCyc;
        int                  wrStart;

        vecs[0]  = '{INSERT_QUERY,  48'h0000_0000_0ABC, 32'h11,        ST_OK,      12'hABC, 4, 1};
        vecs[1]  = '{LOOK_UP_QUERY, 48'h0000_0000_0ABC, 32'h11,        ST_HIT,     12'hABC, 3, 0};
        vecs[2]  = '{INSERT_QUERY,  48'h000A_BC00_0000, 32'h22,        ST_COLLIDE, 12'hABC, 3, 0};
        vecs[3]  = '{LOOK_UP_QUERY, 48'h000A_BC00_0000, 32'h22,        ST_MISS,    12'hABC, 3, 0};
        vecs[4]  = '{LOOK_UP_QUERY, 48'h000A_BC00_0000, 32'h11,        ST_HIT,     12'hABC, 3, 0};
        vecs[5]  = '{INSERT_QUERY,  48'h0000_0000_0123, 32'h0,         ST_INVALID, 12'h123, 1, 0};
        vecs[6]  = '{LOOK_UP_QUERY, 48'h0000_0000_0123, 32'h5,         ST_MISS,    12'h123, 3, 0};
        vecs[7]  = '{INSERT_QUERY,  48'hFFFF_FFFF_FFFF, 32'h7,         ST_OK,      12'h000, 4, 1};
        vecs[8]  = '{INSERT_QUERY,  48'h0000_0000_0FFF, 32'hFFFF_FFFF, ST_OK,      12'hFFF, 4, 1};
        vecs[9]  = '{LOOK_UP_QUERY, 48'h0000_0000_0FFF, 32'hFFFF_FFFF, ST_HIT,     12'hFFF, 3, 0};
        vecs[10] = '{INSERT_QUERY,  48'h0000_0000_0ABC, 32'h11,        ST_COLLIDE, 12'hABC, 3, 0};
        vecs[11] = '{LOOK_UP_QUERY, 48'h1234_5678_9ABC, 32'h1,         ST_MISS,    12'h840, 3, 0};

        repeat (3) @(negedge clk);
        checkOutput("resetOutputs",
            {req_ready_o, res_valid_o, init_done_o, tbl_wr_en_o, tbl_query_o, res_status_o,
             res_hash_o, tbl_wr_key_o, tbl_rd_key_o, tbl_val_o}, 64'd0);

        req_valid_i = 1'b1;
        req_query_i = LOOK_UP_QUERY;
        req_key_i   = 48'h1;
        req_val_i   = 32'h1;
        runInit();
        req_valid_i = 1'b0;
        @(negedge clk);
        while (!req_ready_o) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].q, vecs[i].key, vecs[i].val, st, h, lat, wrs, wk, wv);
            checkOutput($sformatf("vec%0d status", i), 64'(st), 64'(vecs[i].expSt));
            checkOutput($sformatf("vec%0d hash", i), 64'(h), 64'(vecs[i].expHash));
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d writes", i), 64'(wrs), 64'(vecs[i].expWr));
            if (vecs[i].expWr == 1) begin
                checkOutput($sformatf("vec%0d wrKey", i), 64'(wk), 64'(vecs[i].expHash));
                checkOutput($sformatf("vec%0d wrVal", i), 64'(wv), 64'(vecs[i].val));
            end
        end

        // Result back-pressure with a second request already waiting.
        req_query_i = LOOK_UP_QUERY;
        req_key_i   = 48'h0000_0000_0ABC;
        req_val_i   = 32'h11;
        req_valid_i = 1'b1;
        res_ready_i = 1'b0;
        waitCyc = 0;
        while (!req_ready_o && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        @(negedge clk);
        req_query_i = INSERT_QUERY;
        req_key_i   = 48'h0000_0000_0555;
        req_val_i   = 32'h9;
        lat = 1;
        while (!res_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("holdLatency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold%0d", i), {res_valid_o, req_ready_o, res_status_o, res_hash_o},
                        {1'b1, 1'b0, 3'(ST_HIT), 12'hABC});
            @(negedge clk);
        end
        applyStimulus(INSERT_QUERY, 48'h0000_0000_0555, 32'h9, st, h, lat, wrs, wk, wv);
        checkOutput("heldReq status", 64'(st), 64'(ST_OK));
        checkOutput("heldReq hash", 64'(h), 64'h555);
        checkOutput("heldReq latency", 64'(lat), 64'd4);
        checkOutput("heldReq writes", 64'(wrs), 64'd1);

        // Reset during the WRITE cycle must cancel the write and restart the sweep.
        req_query_i = INSERT_QUERY;
        req_key_i   = 48'h0000_0000_0777;
        req_val_i   = 32'hAB;
        req_valid_i = 1'b1;
        res_ready_i = 1'b1;
        waitCyc = 0;
        while (!req_ready_o && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        waitCyc = 0;
        while (!tbl_wr_en_o && waitCyc < 10) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("reachWrite", 64'(tbl_wr_en_o), 64'd1);
        wrStart = wrCount;
        rst_n = 1'b0;
        #1;
        checkOutput("abortOutputs", {tbl_wr_en_o, res_valid_o, req_ready_o, init_done_o}, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("abortNoWrite", 64'(wrCount - wrStart), 64'd0);
        checkOutput("abortSlotEmpty", 64'(mem[12'h777]), 64'd0);
        runInit();

        for (int i = 0; i < 6; i++) begin
            pool[i]     = {16'($urandom), 32'($urandom)};
            x           = 12'($urandom);
            pool[i + 6] = pool[i] ^ ({36'd0, x} << 12) ^ ({36'd0, x} << 24);
        end
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            k = pool[$urandom_range(0, 11)];
            q = ($urandom_range(0, 1) == 1) ? INSERT_QUERY : LOOK_UP_QUERY;
            v = (q == INSERT_QUERY) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(1, 3));
            x = tbFold(k);
            if (q == INSERT_QUERY) begin
                if (v == '0)                expSt = ST_INVALID;
                else if (refMem.exists(x))  expSt = ST_COLLIDE;
                else begin
                    expSt     = ST_OK;
                    refMem[x] = v;
                end
            end else begin
                expSt = (refMem.exists(x) && refMem[x] == v) ? ST_HIT : ST_MISS;
            end
            applyStimulus(q, k, v, st, h, lat, wrs, wk, wv);
            checkOutput($sformatf("rnd%0d status", n), 64'(st), 64'(expSt));
            checkOutput($sformatf("rnd%0d hash", n), 64'(h), 64'(x));
            checkOutput($sformatf("rnd%0d latency", n), 64'(lat), 64'(expLatency(expSt)));
            checkOutput($sformatf("rnd%0d writes", n), 64'(wrs), (expSt == 3'(ST_OK)) ? 64'd1 : 64'd0);
            if (expSt == 3'(ST_OK)) begin
                checkOutput($sformatf("rnd%0d wrKey", n), 64'(wk), 64'(x));
                checkOutput($sformatf("rnd%0d wrVal", n), 64'(wv), 64'(v));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
